// File: rtl/sik_pkg.sv
// Shared SIK definitions: stack op codes and default word width, so that the
// decode stage and the stack file agree on encoding.
package sik_pkg;

  localparam int SIK_WORD = 16;

  typedef enum logic [2:0] {
    SIK_SOP_NOP   = 3'd0,
    SIK_SOP_PUSH  = 3'd1,
    SIK_SOP_POP   = 3'd2,
    SIK_SOP_GET   = 3'd3,
    SIK_SOP_PUT   = 3'd4,
    SIK_SOP_PEEK2 = 3'd5,
    SIK_SOP_BINOP = 3'd6,
    SIK_SOP_CLEAR = 3'd7
  } sik_sop_e;

endpackage

// File: rtl/sik_stack_file_if.sv
// Operation request / registered response bundle between execute and the
// stack file. Widths follow the stack file parameters.
interface sik_stack_file_if #(
  parameter int WIDTH   = sik_pkg::SIK_WORD,
  parameter int DEPTH   = 256,
  parameter int THREADS = 2
);
  localparam int IW = $clog2(DEPTH);
  localparam int TW = (THREADS > 1) ? $clog2(THREADS) : 1;

  logic             op_valid;
  logic [TW-1:0]    op_tid;
  logic [2:0]       op_code;
  logic [IW-1:0]    op_index;
  logic [WIDTH-1:0] op_data;

  logic             rsp_valid;
  logic [TW-1:0]    rsp_tid;
  logic [WIDTH-1:0] rsp_data;
  logic [WIDTH-1:0] rsp_data2;
  logic             rsp_fault;

  modport master (
    output op_valid, op_tid, op_code, op_index, op_data,
    input  rsp_valid, rsp_tid, rsp_data, rsp_data2, rsp_fault
  );

  modport slave (
    input  op_valid, op_tid, op_code, op_index, op_data,
    output rsp_valid, rsp_tid, rsp_data, rsp_data2, rsp_fault
  );
endinterface

// File: rtl/sik_stack_ctx.sv
// One thread's stack context: occupancy, sticky fault flag, legality check
// and (with SIK_STACK_HIWATER_EN defined) the occupancy high-water mark.
module sik_stack_ctx
  import sik_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int CW    = $clog2(DEPTH + 1),
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sel,
  input  logic [2:0]    op_code,
  input  logic [IW-1:0] op_index,
  output logic [CW-1:0] cnt,
  output logic          faulted,
  output logic [CW-1:0] hiwater,
  output logic          fault
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          flt_q, flt_d;
  logic [CW-1:0] idx_ext;
  sik_sop_e      op;

  assign op      = sik_sop_e'(op_code);
  assign idx_ext = CW'(op_index);

  // Legality of the presented op against this context, independent of sel.
  always_comb begin
    fault = 1'b0;
    case (op)
      SIK_SOP_PUSH:  fault = (cnt_q == CW'(DEPTH));
      SIK_SOP_POP:   fault = (cnt_q == '0);
      SIK_SOP_GET:   fault = (cnt_q == CW'(DEPTH)) || (idx_ext >= cnt_q);
      SIK_SOP_PUT:   fault = (idx_ext >= cnt_q);
      SIK_SOP_PEEK2,
      SIK_SOP_BINOP: fault = (cnt_q < CW'(2));
      default:       fault = 1'b0;
    endcase
    if (flt_q && (op != SIK_SOP_CLEAR) && (op != SIK_SOP_NOP)) fault = 1'b1;
  end

  // Occupancy and sticky fault next state; only the selected context moves.
  always_comb begin
    cnt_d = cnt_q;
    flt_d = flt_q;
    if (sel) begin
      if (op == SIK_SOP_CLEAR) begin
        cnt_d = '0;
        flt_d = 1'b0;
      end else if (fault) begin
        flt_d = 1'b1;
      end else begin
        case (op)
          SIK_SOP_PUSH, SIK_SOP_GET:                cnt_d = cnt_q + CW'(1);
          SIK_SOP_POP, SIK_SOP_PUT, SIK_SOP_BINOP:  cnt_d = cnt_q - CW'(1);
          default:                                  cnt_d = cnt_q;
        endcase
      end
    end
  end

  // Context state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      flt_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      flt_q <= flt_d;
    end
  end

  assign cnt     = cnt_q;
  assign faulted = flt_q;

`ifdef SIK_STACK_HIWATER_EN
  logic [CW-1:0] hw_q, hw_d;

  // Track the peak occupancy seen since reset or the last CLEAR.
  always_comb begin
    hw_d = hw_q;
    if (sel && (op == SIK_SOP_CLEAR)) hw_d = '0;
    else if (cnt_d > hw_q)            hw_d = cnt_d;
  end

  // High-water register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hw_q <= '0;
    else        hw_q <= hw_d;
  end

  assign hiwater = hw_q;
`else
  assign hiwater = '0;
`endif

endmodule

// File: rtl/sik_stack_file.sv
// Multi-thread operand stack store. One op per cycle, response registered one
// cycle later. Per-thread bookkeeping lives in sik_stack_ctx instances; this
// level owns the shared word array and the response registers.
// Optional feature macro: SIK_STACK_HIWATER_EN (per-thread high-water marks).
module sik_stack_file
  import sik_pkg::*;
#(
  parameter  int WIDTH   = SIK_WORD,
  parameter  int DEPTH   = 256,
  parameter  int THREADS = 2,
  localparam int CW      = $clog2(DEPTH + 1),
  localparam int IW      = $clog2(DEPTH),
  localparam int TW      = (THREADS > 1) ? $clog2(THREADS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  sik_stack_file_if.slave       bus,
  output logic [THREADS*CW-1:0] count,
  output logic [THREADS-1:0]    faulted,
  output logic [THREADS*CW-1:0] hiwater
);

  localparam int AW = TW + IW;

  logic [THREADS-1:0][CW-1:0] ctx_cnt, ctx_hw;
  logic [THREADS-1:0]         ctx_flt, ctx_fault;

  logic             tid_ok, fault;
  logic [TW-1:0]    tid;
  logic [CW-1:0]    cnt, s_top, s_sec, s_idx;
  logic [AW-1:0]    a_push, a_top, a_sec, a_idx;
  logic [WIDTH-1:0] rd_top, rd_sec, rd_idx;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;

  logic [WIDTH-1:0] mem_q [THREADS*DEPTH];

  logic             rsp_valid_q, rsp_valid_d;
  logic [TW-1:0]    rsp_tid_q, rsp_tid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [WIDTH-1:0] rsp_data2_q, rsp_data2_d;
  logic             rsp_fault_q, rsp_fault_d;

  genvar t;
  generate
    for (t = 0; t < THREADS; t++) begin : g_ctx
      sik_stack_ctx #(.DEPTH(DEPTH), .CW(CW), .IW(IW)) u_ctx (
        .clk      (clk),
        .reset    (reset),
        .sel      (bus.op_valid && tid_ok && (bus.op_tid == TW'(t))),
        .op_code  (bus.op_code),
        .op_index (bus.op_index),
        .cnt      (ctx_cnt[t]),
        .faulted  (ctx_flt[t]),
        .hiwater  (ctx_hw[t]),
        .fault    (ctx_fault[t])
      );
    end
  endgenerate

  assign count   = ctx_cnt;
  assign faulted = ctx_flt;
  assign hiwater = ctx_hw;

  // Thread select, slot arithmetic in count width, and combinational reads.
  always_comb begin
    tid_ok = ({1'b0, bus.op_tid} < (TW+1)'(THREADS));
    tid    = tid_ok ? bus.op_tid : '0;
    cnt    = ctx_cnt[tid];
    fault  = !tid_ok || ctx_fault[tid];
    s_top  = cnt - CW'(1);
    s_sec  = cnt - CW'(2);
    s_idx  = cnt - CW'(1) - CW'(bus.op_index);
    a_push = {tid, IW'(cnt)};
    a_top  = {tid, IW'(s_top)};
    a_sec  = {tid, IW'(s_sec)};
    a_idx  = {tid, IW'(s_idx)};
    rd_top = mem_q[a_top];
    rd_sec = mem_q[a_sec];
    rd_idx = mem_q[a_idx];
  end

  // Per-op storage write and response data; a fault leaves everything alone.
  always_comb begin
    wr_en       = 1'b0;
    wr_addr     = a_push;
    wr_data     = bus.op_data;
    rsp_data_d  = '0;
    rsp_data2_d = '0;
    if (bus.op_valid && !fault) begin
      case (sik_sop_e'(bus.op_code))
        SIK_SOP_PUSH: begin
          wr_en      = 1'b1;
          rsp_data_d = bus.op_data;
        end
        SIK_SOP_POP:  rsp_data_d = rd_top;
        SIK_SOP_GET: begin
          wr_en      = 1'b1;
          wr_data    = rd_idx;
          rsp_data_d = rd_idx;
        end
        SIK_SOP_PUT: begin
          wr_en      = 1'b1;
          wr_addr    = a_idx;
          wr_data    = rd_top;
          rsp_data_d = rd_top;
        end
        SIK_SOP_PEEK2: begin
          rsp_data_d  = rd_top;
          rsp_data2_d = rd_sec;
        end
        SIK_SOP_BINOP: begin
          wr_en      = 1'b1;
          wr_addr    = a_sec;
          rsp_data_d = bus.op_data;
        end
        default: ;
      endcase
    end
    rsp_valid_d = bus.op_valid;
    rsp_tid_d   = bus.op_valid ? bus.op_tid : '0;
    rsp_fault_d = bus.op_valid && fault;
  end

  // Word array: not reset, written at most once per cycle.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // Response registers; reset drops any in-flight response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_q <= 1'b0;
      rsp_tid_q   <= '0;
      rsp_data_q  <= '0;
      rsp_data2_q <= '0;
      rsp_fault_q <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_tid_q   <= rsp_tid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_data2_q <= rsp_data2_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_tid   = rsp_tid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_data2 = rsp_data2_q;
  assign bus.rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_sik_stack_file.sv
// Directed bench for sik_stack_file (WIDTH 16, DEPTH 256, THREADS 2).
// Expected high-water values follow SIK_STACK_HIWATER_EN.
module tb_sik_stack_file;
  import sik_pkg::*;

  localparam int D  = 256;
  localparam int CW = 9;

  logic clk = 1'b0;
  logic reset;
  logic [2*CW-1:0] count;
  logic [1:0]      faulted;
  logic [2*CW-1:0] hiwater;

  int n_chk = 0;
  int n_bad = 0;

  sik_stack_file_if #(.WIDTH(16), .DEPTH(D), .THREADS(2)) bus ();

  sik_stack_file #(.WIDTH(16), .DEPTH(D), .THREADS(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .count   (count),
    .faulted (faulted),
    .hiwater (hiwater)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] cnt_of(input int t);
    return count[t*CW +: CW];
  endfunction

  function automatic logic [CW-1:0] hw_of(input int t);
    return hiwater[t*CW +: CW];
  endfunction

  // Present one op for one edge, then leave the sample point 1 time unit later.
  task automatic do_op(input int tid, input sik_sop_e code, input int idx, input logic [15:0] d);
    bus.op_valid = 1'b1;
    bus.op_tid   = 1'(tid);
    bus.op_code  = code;
    bus.op_index = 8'(idx);
    bus.op_data  = d;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
  endtask

  logic [15:0] mstk [2][D];
  int          mcnt [2];
  logic [15:0] exp_d;
  int          hw_exp;

  initial begin
    reset        = 1'b0;
    bus.op_valid = 1'b0;
    bus.op_tid   = '0;
    bus.op_code  = '0;
    bus.op_index = '0;
    bus.op_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.rsp_valid), 0);
    chk("rst_data",  32'(bus.rsp_data), 0);
    chk("rst_fault", 32'(bus.rsp_fault), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_faulted", 32'(faulted), 0);
    chk("rst_hiwater", 32'(hiwater), 0);
    reset = 1'b1;

    // PUSH, PUSH, PEEK2 on tid 0
    do_op(0, SIK_SOP_PUSH, 0, 16'h1111);
    chk("push1_valid", 32'(bus.rsp_valid), 1);
    chk("push1_data",  32'(bus.rsp_data), 32'h1111);
    chk("push1_cnt",   32'(cnt_of(0)), 1);
    do_op(0, SIK_SOP_PUSH, 0, 16'h2222);
    do_op(0, SIK_SOP_PEEK2, 0, 16'h0);
    chk("peek2_d",   32'(bus.rsp_data), 32'h2222);
    chk("peek2_d2",  32'(bus.rsp_data2), 32'h1111);
    chk("peek2_c0",  32'(cnt_of(0)), 2);
    chk("peek2_c1",  32'(cnt_of(1)), 0);
    do_op(0, SIK_SOP_NOP, 0, 16'h5555);
    chk("nop_valid", 32'(bus.rsp_valid), 1);
    chk("nop_data",  32'(bus.rsp_data), 0);

    // Fill tid 1, overflow, fault stickiness, CLEAR recovery
    for (int i = 0; i < D; i++) do_op(1, SIK_SOP_PUSH, 0, 16'(i));
    chk("full_cnt", 32'(cnt_of(1)), D);
    do_op(1, SIK_SOP_PUSH, 0, 16'hdead);
    chk("ovf_fault",   32'(bus.rsp_fault), 1);
    chk("ovf_data",    32'(bus.rsp_data), 0);
    chk("ovf_faulted", 32'(faulted[1]), 1);
    chk("ovf_cnt",     32'(cnt_of(1)), D);
    chk("ovf_tid",     32'(bus.rsp_tid), 1);
    do_op(1, SIK_SOP_POP, 0, 16'h0);
    chk("sticky_fault", 32'(bus.rsp_fault), 1);
    chk("sticky_cnt",   32'(cnt_of(1)), D);
    chk("t0_untouched", 32'(faulted[0]), 0);
    do_op(1, SIK_SOP_CLEAR, 0, 16'h0);
    chk("clr_fault",   32'(bus.rsp_fault), 0);
    chk("clr_cnt",     32'(cnt_of(1)), 0);
    chk("clr_faulted", 32'(faulted[1]), 0);

    // GET / PUT / BINOP on stack 5,6,7
    do_op(0, SIK_SOP_CLEAR, 0, 16'h0);
    do_op(0, SIK_SOP_PUSH, 0, 16'h5);
    do_op(0, SIK_SOP_PUSH, 0, 16'h6);
    do_op(0, SIK_SOP_PUSH, 0, 16'h7);
    do_op(0, SIK_SOP_GET, 2, 16'h0);
    chk("get_data", 32'(bus.rsp_data), 5);
    chk("get_cnt",  32'(cnt_of(0)), 4);
    do_op(0, SIK_SOP_GET, 4, 16'h0);
    chk("get_oob_fault", 32'(bus.rsp_fault), 1);
    do_op(0, SIK_SOP_CLEAR, 0, 16'h0);
    do_op(0, SIK_SOP_PUSH, 0, 16'h5);
    do_op(0, SIK_SOP_PUSH, 0, 16'h6);
    do_op(0, SIK_SOP_PUSH, 0, 16'h7);
    do_op(0, SIK_SOP_GET, 2, 16'h0);
    do_op(0, SIK_SOP_PUT, 3, 16'h0);
    chk("put_data", 32'(bus.rsp_data), 5);
    chk("put_cnt",  32'(cnt_of(0)), 3);
    do_op(0, SIK_SOP_BINOP, 0, 16'hB);
    chk("binop_data", 32'(bus.rsp_data), 32'hB);
    chk("binop_cnt",  32'(cnt_of(0)), 2);
    do_op(0, SIK_SOP_PEEK2, 0, 16'h0);
    chk("after_binop_top", 32'(bus.rsp_data), 32'hB);
    chk("after_binop_bot", 32'(bus.rsp_data2), 5);
    do_op(0, SIK_SOP_POP, 0, 16'h0);
    do_op(0, SIK_SOP_PEEK2, 0, 16'h0);
    chk("peek2_short_fault", 32'(bus.rsp_fault), 1);
    chk("peek2_short_cnt",   32'(cnt_of(0)), 1);
    do_op(0, SIK_SOP_CLEAR, 0, 16'h0);
    do_op(0, SIK_SOP_PUT, 0, 16'h0);
    chk("put_empty_fault", 32'(bus.rsp_fault), 1);
    do_op(0, SIK_SOP_CLEAR, 0, 16'h0);

    // Interleaved per-thread PUSH/POP against a small model
    mcnt[0] = 0;
    mcnt[1] = 0;
    for (int i = 0; i < 200; i++) begin
      int th;
      th = i % 2;
      if (mcnt[th] == 0 || ((i / 2) % 3) != 2) begin
        exp_d = 16'(i * 16'h0101) ^ 16'(th << 15);
        mstk[th][mcnt[th]] = exp_d;
        mcnt[th]++;
        do_op(th, SIK_SOP_PUSH, 0, exp_d);
      end else begin
        mcnt[th]--;
        exp_d = mstk[th][mcnt[th]];
        do_op(th, SIK_SOP_POP, 0, 16'h0);
      end
      chk("mix_data",  32'(bus.rsp_data), 32'(exp_d));
      chk("mix_fault", 32'(bus.rsp_fault), 0);
      chk("mix_c0",    32'(cnt_of(0)), 32'(mcnt[0]));
      chk("mix_c1",    32'(cnt_of(1)), 32'(mcnt[1]));
    end

    // Reset mid-stream with count[0] = 3 and a response in flight
    do_op(0, SIK_SOP_CLEAR, 0, 16'h0);
    do_op(0, SIK_SOP_PUSH, 0, 16'h1);
    do_op(0, SIK_SOP_PUSH, 0, 16'h2);
    do_op(0, SIK_SOP_PUSH, 0, 16'h3);
    chk("pre_rst_cnt", 32'(cnt_of(0)), 3);
    bus.op_valid = 1'b1;
    bus.op_tid   = 1'b0;
    bus.op_code  = SIK_SOP_PUSH;
    bus.op_data  = 16'h99;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_async_cnt",   32'(cnt_of(0)), 0);
    chk("rst_async_valid", 32'(bus.rsp_valid), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    chk("post_rel_valid", 32'(bus.rsp_valid), 0);
    @(posedge clk); #1;
    chk("post_rel_valid2", 32'(bus.rsp_valid), 0);
    do_op(0, SIK_SOP_PUSH, 0, 16'hAA);
    chk("post_rst_cnt", 32'(cnt_of(0)), 1);
    do_op(0, SIK_SOP_GET, 0, 16'h0);
    chk("post_rst_slot0", 32'(bus.rsp_data), 32'hAA);
    do_op(0, SIK_SOP_CLEAR, 0, 16'h0);

    // High-water: push 4, pop 3, push 1
    for (int i = 0; i < 4; i++) do_op(0, SIK_SOP_PUSH, 0, 16'(i));
    for (int i = 0; i < 3; i++) do_op(0, SIK_SOP_POP, 0, 16'h0);
    do_op(0, SIK_SOP_PUSH, 0, 16'h4);
`ifdef SIK_STACK_HIWATER_EN
    hw_exp = 4;
`else
    hw_exp = 0;
`endif
    chk("hw_t0", 32'(hw_of(0)), 32'(hw_exp));
    chk("hw_t1", 32'(hw_of(1)), 0);
    chk("hw_cnt", 32'(cnt_of(0)), 2);
    do_op(0, SIK_SOP_CLEAR, 0, 16'h0);
    chk("hw_clr", 32'(hw_of(0)), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/sik_stack_file.md
# sik_stack_file

Parametrised multi-thread operand-stack store for the pipelined SIK processor. Holds one hardware stack per thread context in a single flop array and applies one stack operation per cycle, issued by the execute stage: push, pop, indexed get/put, two-entry peek, or binary-op replace. Each response is registered one cycle later. Per-thread occupancy and sticky fault tracking replace the hard-wired two-thread sp1/sp2 scheme, generalising word width, stack depth and thread count.

## Interface
- WIDTH, 16: stack word width in bits.
- DEPTH, 256: entries per thread stack; power of two, at least 2.
- THREADS, 2: number of thread contexts, at least 1.
- Derived: CW = $clog2(DEPTH+1) (count width); IW = $clog2(DEPTH) (index width); TW = max(1, $clog2(THREADS)).
- clk  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; asserted (0) clears all control state immediately.
- op_valid  in  1  operation present this cycle; always accepted, no backpressure.
- op_tid  in  TW  target thread; values at or above THREADS → fault.
- op_code  in  3  0 NOP, 1 PUSH, 2 POP, 3 GET, 4 PUT, 5 PEEK2, 6 BINOP, 7 CLEAR.
- op_index  in  IW  depth below top for GET/PUT; 0 = top.
- op_data  in  WIDTH  value for PUSH and BINOP.
- rsp_valid  out  1  response for the op accepted in the previous cycle.
- rsp_tid  out  TW  echoed thread id.
- rsp_data  out  WIDTH  primary read value.
- rsp_data2  out  WIDTH  second entry (PEEK2 only), else 0.
- rsp_fault  out  1  op rejected; no state changed.
- count  out  THREADS*CW  per-thread occupancy, thread t at [t*CW +: CW].
- faulted  out  THREADS  sticky per-thread fault flags.
- hiwater  out  THREADS*CW  per-thread maximum occupancy (see Configuration).

## Operation
- Storage: THREADS*DEPTH words. Slot s of thread t is at address t*DEPTH+s. Top of stack is slot count-1. Storage is not reset.
- PUSH: write op_data to slot count; count+1. rsp_data = op_data.
- POP: rsp_data = top; count-1.
- GET: rsp_data = slot count-1-index; that value is pushed (count+1).
- PUT: top is written to slot count-1-index; then pop (count-1). rsp_data = top. PUT with index 0 is a plain pop.
- PEEK2: rsp_data = top, rsp_data2 = top-1. No change.
- BINOP: pops two and pushes op_data (net count-1; op_data lands in the old slot count-2). rsp_data = op_data.
- CLEAR: count = 0 and faulted[t] cleared. Never faults for a valid tid.
- NOP: rsp_valid = 1, rsp_data = 0, no state change.
- Fault conditions:
  - PUSH when count == DEPTH.
  - POP or PUT when count == 0.
  - GET when count == DEPTH, or index ≥ count.
  - PUT when index ≥ count.
  - PEEK2 or BINOP when count < 2.
  - Any op other than CLEAR or NOP on a thread with faulted set.
  - op_tid out of range.
- On fault: count and storage unchanged; rsp_fault = 1 and rsp_data = 0; faulted[t] is set (except for an out-of-range tid).

## Timing
- Op accepted at edge N → response valid in cycle N+1. Throughput is one op per cycle. count and faulted update at edge N.
- Storage read is combinational from the array and the result is registered. A PUSH at edge N followed by a POP at edge N+1 on the same thread returns the pushed value; no forwarding stage is needed.
- Reset values: rsp_valid 0, rsp_tid 0, rsp_data 0, rsp_data2 0, rsp_fault 0, every count 0, faulted all 0, hiwater all 0.
- Reset asserted mid-stream: any pending response is dropped, and the first cycle after release has rsp_valid = 0.
- count is exact over 0..DEPTH; there is no wrap. Index arithmetic is done in CW bits.

## Configuration
- SIK_STACK_HIWATER_EN defined: hiwater[t] updates at the same edge as count to max(hiwater, new count). It clears on reset or CLEAR of thread t.
- SIK_STACK_HIWATER_EN undefined: hiwater is tied to 0 and no watermark registers are built.

## Structure
- Shared package sik_pkg holds the op_code constants (SIK_SOP_NOP…SIK_SOP_CLEAR) and the WORD width default, so decode and this block agree.
- Sub-module sik_stack_ctx, instantiated THREADS times, owns one thread's count, faulted flag, hiwater and legality check. The top level owns the array and the response registers.

## Test plan
- Reset, then PUSH 0x1111 and PUSH 0x2222 on tid 0, then PEEK2 → rsp_data 0x2222, rsp_data2 0x1111, count[0] = 2, count[1] = 0.
- Push DEPTH words 0..DEPTH-1 on tid 1, then one more PUSH → final op rsp_fault = 1, faulted[1] = 1, count[1] = DEPTH. Next POP on tid 1 → fault. CLEAR tid 1 → count 0, faulted 0.
- Stack 5, 6, 7 (top 7) on tid 0:
  - GET index 2 → rsp_data 5, count 4.
  - PUT index 3 → slot 0 becomes 5, count 3.
  - BINOP op_data 0xB → stack 5, 0xB.
- Interleave tid 0 and tid 1 PUSH/POP every cycle, 200 ops → each response equals the per-thread model and count never bleeds between threads.
- Assert reset for 1 cycle mid-stream with count[0] = 3 → count 0 immediately, rsp_valid 0 in the following cycle, and the next PUSH lands in slot 0.
- With SIK_STACK_HIWATER_EN defined: push 4, pop 3, push 1 → hiwater[0] = 4. Undefined → hiwater stays 0.
